// File: rtl/tia_playfield_pkg.sv
// Shared constants for the TIA playfield sequencer: write addresses,
// horizontal counter width and the four colour-clock phase encodings.
package tia_playfield_pkg;

  localparam int HCOUNT_W = 6;

  localparam logic [5:0] ADDR_RSYNC  = 6'h03;
  localparam logic [5:0] ADDR_CTRLPF = 6'h0A;
  localparam logic [5:0] ADDR_PF0    = 6'h0D;
  localparam logic [5:0] ADDR_PF1    = 6'h0E;
  localparam logic [5:0] ADDR_PF2    = 6'h0F;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_e;

endpackage

// File: rtl/tia_playfield_sequencer_if.sv
// CPU write bus into the sequencer. wr_en is a single-cycle strobe that
// qualifies wr_addr/wr_data; there is no ready, every strobed write is taken.
interface tia_playfield_sequencer_if;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/tia_hphase_gen.sv
// Colour-clock phase counter with registered, non-overlapping phase decode.
// resync forces the next phase to 0 regardless of the current one.
module tia_hphase_gen
  import tia_playfield_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   resync,
  output phase_e phase,
  output logic   hphi1,
  output logic   hphi2,
  output logic   clkp
);

  phase_e phase_next;

  always_comb begin
    phase_next = PH0;
    if (!resync) begin
      case (phase)
        PH0:     phase_next = PH1;
        PH1:     phase_next = PH2;
        PH2:     phase_next = PH3;
        default: phase_next = PH0;
      endcase
    end
  end

  // Decoding from phase_next keeps the strobes aligned with the phase register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase <= PH0;
      hphi1 <= 1'b1;
      hphi2 <= 1'b0;
      clkp  <= 1'b0;
    end else begin
      phase <= phase_next;
      hphi1 <= (phase_next == PH0);
      hphi2 <= (phase_next == PH2);
      clkp  <= (phase_next == PH1) || (phase_next == PH3);
    end
  end

endmodule

// File: rtl/tia_playfield_sequencer.sv
// Playfield timing and register-write sequencer: horizontal count, line
// markers, line-synchronised reflect control and PF0/PF1/PF2 latch strobes.
module tia_playfield_sequencer
  import tia_playfield_pkg::*;
#(
  parameter int RHB_COUNT   = 16,
  parameter int CNT_COUNT   = 36,
  parameter int LINE_COUNTS = 57
) (
  input  logic                      clock,
  input  logic                      reset,
  tia_playfield_sequencer_if.slave  bus,
  output logic                      hphi1,
  output logic                      hphi2,
  output logic                      clkp,
  output logic [HCOUNT_W-1:0]       hcount,
  output logic                      rhb,
  output logic                      cnt,
  output logic                      ref_bar,
  output logic                      pf0,
  output logic                      pf1,
  output logic                      pf2,
  output logic [7:0]                d,
  output logic                      line_end
);

  localparam logic [HCOUNT_W-1:0] LAST_COUNT = HCOUNT_W'(LINE_COUNTS - 1);
  localparam logic [HCOUNT_W-1:0] RHB_VAL    = HCOUNT_W'(RHB_COUNT);
  localparam logic [HCOUNT_W-1:0] CNT_VAL    = HCOUNT_W'(CNT_COUNT);

  phase_e              phase;
  logic                resync;
  logic                wr_ctrlpf;
  logic                wr_pf0, wr_pf1, wr_pf2;
  logic                line_start;
  logic                ref_shadow;
  logic [HCOUNT_W-1:0] hcount_next;

  assign resync    = bus.wr_en && (bus.wr_addr == ADDR_RSYNC);
  assign wr_ctrlpf = bus.wr_en && (bus.wr_addr == ADDR_CTRLPF);
  assign wr_pf0    = bus.wr_en && (bus.wr_addr == ADDR_PF0);
  assign wr_pf1    = bus.wr_en && (bus.wr_addr == ADDR_PF1);
  assign wr_pf2    = bus.wr_en && (bus.wr_addr == ADDR_PF2);

  // RSYNC counts as a line start so a pending reflect change is applied.
  assign line_start = resync || ((phase == PH3) && (hcount == LAST_COUNT));

  tia_hphase_gen u_hphase_gen (
    .clock  (clock),
    .reset  (reset),
    .resync (resync),
    .phase  (phase),
    .hphi1  (hphi1),
    .hphi2  (hphi2),
    .clkp   (clkp)
  );

  always_comb begin
    hcount_next = hcount;
    if (line_start)
      hcount_next = '0;
    else if (phase == PH3)
      hcount_next = hcount + HCOUNT_W'(1);
  end

  // Markers decode the next count so they line up with hcount itself.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hcount   <= '0;
      rhb      <= 1'b0;
      cnt      <= 1'b0;
      line_end <= 1'b0;
    end else begin
      hcount   <= hcount_next;
      rhb      <= (hcount_next == RHB_VAL);
      cnt      <= (hcount_next == CNT_VAL);
      line_end <= !resync && (phase == PH2) && (hcount == LAST_COUNT);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ref_shadow <= 1'b0;
      ref_bar    <= 1'b1;
    end else begin
      if (wr_ctrlpf)
        ref_shadow <= bus.wr_data[0];
      if (line_start)
        ref_bar <= ~ref_shadow;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pf0 <= 1'b0;
      pf1 <= 1'b0;
      pf2 <= 1'b0;
      d   <= 8'h00;
    end else begin
      pf0 <= wr_pf0;
      pf1 <= wr_pf1;
      pf2 <= wr_pf2;
      if (wr_pf0 || wr_pf1 || wr_pf2)
        d <= bus.wr_data;
    end
  end

endmodule

// File: tb/tb_tia_playfield_sequencer.sv
// Directed bench for tia_playfield_sequencer: free-run timing, PF strobes,
// reflect synchronisation, RSYNC, asynchronous reset and ignored addresses.
module tb_tia_playfield_sequencer;

  logic       clock;
  logic       reset;
  logic       hphi1, hphi2, clkp;
  logic [5:0] hcount;
  logic       rhb, cnt, ref_bar;
  logic       pf0, pf1, pf2;
  logic [7:0] d;
  logic       line_end;

  int n_checks = 0;
  int n_fails  = 0;
  int pos      = 0;  // colour clocks since the current line start
  logic [7:0] exp_q[$];

  tia_playfield_sequencer_if bus ();

  tia_playfield_sequencer dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .hphi1    (hphi1),
    .hphi2    (hphi2),
    .clkp     (clkp),
    .hcount   (hcount),
    .rhb      (rhb),
    .cnt      (cnt),
    .ref_bar  (ref_bar),
    .pf0      (pf0),
    .pf1      (pf1),
    .pf2      (pf2),
    .d        (d),
    .line_end (line_end)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: actual=%0h required=%0h (pos %0d, t=%0t)", tag, act, exp, pos, $time);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    pos = (pos + 1) % 228;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] dat);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = dat;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic advance_to(input int p);
    for (int i = 0; i < 228 && pos != p; i++) step();
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_hphi1"}, 32'(hphi1), 32'd1);
    check_eq({tag, "_hphi2"}, 32'(hphi2), 32'd0);
    check_eq({tag, "_clkp"}, 32'(clkp), 32'd0);
    check_eq({tag, "_hcount"}, 32'(hcount), 32'd0);
    check_eq({tag, "_rhb"}, 32'(rhb), 32'd0);
    check_eq({tag, "_cnt"}, 32'(cnt), 32'd0);
    check_eq({tag, "_line_end"}, 32'(line_end), 32'd0);
    check_eq({tag, "_ref_bar"}, 32'(ref_bar), 32'd1);
    check_eq({tag, "_pf0"}, 32'(pf0), 32'd0);
    check_eq({tag, "_pf1"}, 32'(pf1), 32'd0);
    check_eq({tag, "_pf2"}, 32'(pf2), 32'd0);
    check_eq({tag, "_d"}, 32'(d), 32'd0);
  endtask

  // One full free-running line starting at clock 0, then the wrap.
  task automatic run_line(input string tag);
    for (int k = 0; k < 228; k++) begin
      check_eq({tag, "_hphi1"}, 32'(hphi1), 32'((k % 4) == 0));
      check_eq({tag, "_hphi2"}, 32'(hphi2), 32'((k % 4) == 2));
      check_eq({tag, "_clkp"}, 32'(clkp), 32'((k % 2) == 1));
      check_eq({tag, "_hcount"}, 32'(hcount), 32'(k / 4));
      check_eq({tag, "_rhb"}, 32'(rhb), 32'((k >= 64) && (k <= 67)));
      check_eq({tag, "_cnt"}, 32'(cnt), 32'((k >= 144) && (k <= 147)));
      check_eq({tag, "_line_end"}, 32'(line_end), 32'(k == 227));
      step();
    end
    check_eq({tag, "_wrap_hcount"}, 32'(hcount), 32'd0);
    check_eq({tag, "_wrap_hphi1"}, 32'(hphi1), 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 6'h00;
    bus.wr_data = 8'h00;
    repeat (3) @(negedge clock);
    check_reset_values("rst");

    // 1: free run
    reset = 1'b0;
    pos   = 0;
    run_line("run1");

    // 2: back-to-back PF writes
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hFF);
    bus.wr_en = 1'b1; bus.wr_addr = 6'h0D; bus.wr_data = 8'hA5;
    step();
    check_eq("pf_a_pf0", 32'(pf0), 32'd1);
    check_eq("pf_a_pf1", 32'(pf1), 32'd0);
    check_eq("pf_a_d", 32'(d), 32'(exp_q.pop_front()));
    bus.wr_addr = 6'h0E; bus.wr_data = 8'h3C;
    step();
    check_eq("pf_b_pf0", 32'(pf0), 32'd0);
    check_eq("pf_b_pf1", 32'(pf1), 32'd1);
    check_eq("pf_b_d", 32'(d), 32'(exp_q.pop_front()));
    bus.wr_addr = 6'h0F; bus.wr_data = 8'hFF;
    step();
    bus.wr_en = 1'b0;
    check_eq("pf_c_pf1", 32'(pf1), 32'd0);
    check_eq("pf_c_pf2", 32'(pf2), 32'd1);
    check_eq("pf_c_d", 32'(d), 32'(exp_q.pop_front()));
    step();
    check_eq("pf_idle_pf0", 32'(pf0), 32'd0);
    check_eq("pf_idle_pf1", 32'(pf1), 32'd0);
    check_eq("pf_idle_pf2", 32'(pf2), 32'd0);
    check_eq("pf_hold_d", 32'(d), 32'hFF);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

    // 3: reflect change held until the next line start
    advance_to(80);
    check_eq("ref_hcount20", 32'(hcount), 32'd20);
    wr(6'h0A, 8'h01);
    while (pos != 0) begin
      check_eq("ref_set_hold", 32'(ref_bar), 32'd1);
      step();
    end
    check_eq("ref_set_wrap", 32'(ref_bar), 32'd0);
    advance_to(40);
    wr(6'h0A, 8'h00);
    while (pos != 0) begin
      check_eq("ref_clr_hold", 32'(ref_bar), 32'd0);
      step();
    end
    check_eq("ref_clr_wrap", 32'(ref_bar), 32'd1);

    // 4: RSYNC at hcount 30, phase 2
    advance_to(122);
    check_eq("rsync_pre_hcount", 32'(hcount), 32'd30);
    check_eq("rsync_pre_hphi2", 32'(hphi2), 32'd1);
    wr(6'h03, 8'h00);
    pos = 0;
    check_eq("rsync_hcount", 32'(hcount), 32'd0);
    check_eq("rsync_hphi1", 32'(hphi1), 32'd1);
    check_eq("rsync_hphi2", 32'(hphi2), 32'd0);
    check_eq("rsync_clkp", 32'(clkp), 32'd0);
    check_eq("rsync_line_end", 32'(line_end), 32'd0);
    advance_to(63);
    check_eq("rsync_rhb_63", 32'(rhb), 32'd0);
    step();
    check_eq("rsync_rhb_64", 32'(rhb), 32'd1);

    // RSYNC just before line_end: suppresses it and applies the shadow
    advance_to(200);
    wr(6'h0A, 8'h01);
    advance_to(226);
    check_eq("rsync2_ref_pre", 32'(ref_bar), 32'd1);
    wr(6'h03, 8'h00);
    pos = 0;
    check_eq("rsync2_line_end", 32'(line_end), 32'd0);
    check_eq("rsync2_hcount", 32'(hcount), 32'd0);
    check_eq("rsync2_ref_bar", 32'(ref_bar), 32'd0);
    step();
    check_eq("rsync2_line_end_next", 32'(line_end), 32'd0);

    // 5: asynchronous reset mid-line together with a PF1 write
    advance_to(100);
    bus.wr_en = 1'b1; bus.wr_addr = 6'h0E; bus.wr_data = 8'h55;
    #2 reset = 1'b1;
    #1 check_reset_values("arst");
    bus.wr_en = 1'b0;
    @(negedge clock);
    check_eq("arst_held_pf1", 32'(pf1), 32'd0);
    check_eq("arst_held_d", 32'(d), 32'd0);
    reset = 1'b0;
    pos   = 0;
    run_line("run2");

    // 6: ignored address leaves everything alone
    wr(6'h0D, 8'h5A);
    check_eq("ign_pre_d", 32'(d), 32'h5A);
    wr(6'h09, 8'hFF);
    check_eq("ign_pf0", 32'(pf0), 32'd0);
    check_eq("ign_pf1", 32'(pf1), 32'd0);
    check_eq("ign_pf2", 32'(pf2), 32'd0);
    check_eq("ign_d", 32'(d), 32'h5A);
    check_eq("ign_ref_bar", 32'(ref_bar), 32'd1);
    check_eq("ign_hcount", 32'(hcount), 32'(pos / 4));
    advance_to(0);
    check_eq("ign_ref_wrap", 32'(ref_bar), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/tia_playfield_sequencer.md
# tia_playfield_sequencer

Timing and register-write sequencer for the TIA playfield datapath. Runs off the colour clock and produces everything the playfield shift register block consumes:
- the two non-overlapping horizontal phases `hphi1`/`hphi2` and the output strobe `clkp`;
- the line-position markers `rhb` (start of visible line) and `cnt` (centre of line);
- the line-synchronised reflect control `ref_bar`;
- the PF0/PF1/PF2 latch-enable strobes with their data byte.

It sits between the CPU write bus decode and the playfield register block.

## Interface
Parameters:
- `RHB_COUNT`, 16: hcount value during which `rhb` is high.
- `CNT_COUNT`, 36: hcount value during which `cnt` is high.
- `LINE_COUNTS`, 57: horizontal counts per line; each count is 4 colour clocks, 228 clocks per line.

Ports:
- `clock`  in  1  colour clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  single-cycle register write strobe.
- `wr_addr`  in  6  TIA write address.
- `wr_data`  in  8  write data.
- `hphi1`  out  1  phase 1, high in clock-phase 0.
- `hphi2`  out  1  phase 2, high in clock-phase 2.
- `clkp`  out  1  pixel strobe, high in phases 1 and 3.
- `hcount`  out  6  current horizontal count, 0..56.
- `rhb`  out  1  high for all 4 clocks of `hcount == RHB_COUNT`.
- `cnt`  out  1  high for all 4 clocks of `hcount == CNT_COUNT`.
- `ref_bar`  out  1  inverted, line-synchronised CTRLPF bit 0.
- `pf0`, `pf1`, `pf2`  out  1 each  latch-enable strobes.
- `d`  out  8  data presented to the playfield latches.
- `line_end`  out  1  one-clock pulse in the last clock of hcount 56.

## Operation
- **Phase counter:** 2-bit phase, 0→1→2→3→0 each `clock`. `hphi1`, `hphi2` and `clkp` decode from it as registered outputs, so they are glitch-free and non-overlapping.
- **Horizontal counter:**
  - `hcount` increments when phase goes 3→0.
  - Wraps 56→0.
  - Binary, not LFSR.
- **Writes** are decoded only when `wr_en` = 1:
  - **PF0 (0x0D), PF1 (0x0E), PF2 (0x0F):** on the next clock, the matching `pfN` is high for exactly 1 clock and `d` = `wr_data`. `d` holds its value until the next PF write.
  - **CTRLPF (0x0A):** bit 0 goes to shadow register `ref_shadow`. `ref_bar` updates to `~ref_shadow` only at the clock where `hcount` wraps 56→0, so reflect never changes mid-line.
  - **RSYNC (0x03):** on the next clock, phase = 0 and `hcount` = 0. This clock is treated as a line start, so any pending `ref_shadow` is applied. `line_end` is not pulsed.
  - All other addresses are ignored.
- **Back-to-back writes:** consecutive PF writes on consecutive clocks give consecutive strobes. The last written data wins on `d`. No write is dropped.
- **Reset (asynchronous, any time):**
  - phase = 0, `hcount` = 0.
  - `hphi1` = 1, `hphi2` = 0, `clkp` = 0.
  - `rhb` = `cnt` = 0, `line_end` = 0.
  - `ref_bar` = 1, `ref_shadow` = 0.
  - `pf0` = `pf1` = `pf2` = 0, `d` = 0.
  - A write in flight is discarded.

## Timing
- Colour clocks per line: 228. Lines always start at phase 0 with `hcount` = 0.
- `rhb`, `cnt` and `line_end` are registered. They align with the `hcount` value they decode; there is no extra lag.
- Write-to-strobe latency: 1 clock. The strobe is independent of phase.
- CTRLPF-to-`ref_bar` latency: takes effect at the next line start, 1–228 clocks.
- Simultaneous RSYNC write and natural wrap: RSYNC wins; the result is identical to a wrap.

## Structure
- Package `tia_playfield_pkg`:
  - address constants `ADDR_PF0`, `ADDR_PF1`, `ADDR_PF2`, `ADDR_CTRLPF`, `ADDR_RSYNC`;
  - `HCOUNT_W` = 6;
  - phase encodings.
- Sub-module `tia_hphase_gen`: the phase counter and the phase/strobe decode. It takes a synchronous `resync` input driven by the RSYNC decode.
- The top level holds `hcount`, the write decode, the CTRLPF shadow and the marker decode.

## Test plan
1. **Reset and free run:** release reset, run 228 clocks.
   - `hphi1` high at clocks 0, 4, 8…; `hphi2` high at clocks 2, 6…
   - `rhb` high for clocks 64–67, `cnt` high for clocks 144–147.
   - `line_end` high at clock 227; `hcount` back at 0 at clock 228.
2. **PF writes:** write 0x0D/0xA5, then 0x0E/0x3C, then 0x0F/0xFF on consecutive clocks.
   - `pf0`, `pf1`, `pf2` each pulse once on successive clocks.
   - `d` steps A5 → 3C → FF and holds FF.
3. **Reflect sync:** write 0x0A/0x01 at `hcount` 20.
   - `ref_bar` stays 1 through `hcount` 56.
   - `ref_bar` goes 0 exactly at the wrap to 0.
   - Write 0x0A/0x00 → `ref_bar` returns to 1 at the following wrap.
4. **RSYNC:** write 0x03 at `hcount` 30, phase 2.
   - Next clock: phase 0, `hcount` 0, `hphi1` = 1; no `line_end` pulse.
   - Subsequent `rhb` occurs 64 clocks after the RSYNC clock.
5. **Mid-operation reset:** assert `reset` asynchronously mid-line, in the same cycle as a PF1 write.
   - All outputs at reset values immediately, with no `pf1` strobe.
   - After release, the scenario 1 timing repeats from 0.
6. **Ignored address:** write 0x09/0xFF.
   - No strobe; `d`, `ref_bar` and `hcount` unaffected.
